// File: rtl/audio_decimator_pkg.sv
// rtl/audio_decimator_pkg.sv - shared constants and FSM encoding for audio_decimator
//
// Purpose: default timing/width constants and the decimator FSM state type.
// Ports: none (package).
package audio_decimator_pkg;

  // clk cycles per clk_audio half-period minus 1, for the two pixel clocks
  localparam int AUDIO_DIV_PAL  = 327;
  localparam int AUDIO_DIV_NTSC = 342;

  localparam int DEF_IN_WIDTH  = 18;
  localparam int DEF_OUT_WIDTH = 16;
  localparam int DEF_CNT_WIDTH = 10;
  localparam int DEF_ACC_WIDTH = 28;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DIV  = 2'd1,
    ST_SAT  = 2'd2,
    ST_OUT  = 2'd3
  } dec_state_e;

  function automatic int default_audio_div(input bit ntsc);
    return ntsc ? AUDIO_DIV_NTSC : AUDIO_DIV_PAL;
  endfunction

endpackage

// File: rtl/audio_decimator_serial_divider.sv
// rtl/audio_decimator_serial_divider.sv - restoring unsigned divider, one quotient bit per cycle
//
// Purpose: quotient = dividend / divisor in ACC_WIDTH cycles after start.
// Ports:
//   clk, reset_n     clock, synchronous active-low reset
//   start            load operands (ignored while busy)
//   dividend         unsigned ACC_WIDTH-bit dividend
//   divisor          unsigned CNT_WIDTH-bit divisor, must be nonzero
//   quotient         result register, final from the cycle after done
//   busy             iteration in progress
//   done             high during the last iteration cycle
module serial_divider #(
  parameter int ACC_WIDTH = 28,
  parameter int CNT_WIDTH = 10
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [ACC_WIDTH-1:0] dividend,
  input  logic [CNT_WIDTH-1:0] divisor,
  output logic [ACC_WIDTH-1:0] quotient,
  output logic                 busy,
  output logic                 done
);

  localparam int BW = $clog2(ACC_WIDTH + 1);

  logic [ACC_WIDTH-1:0] quo_q, quo_d;
  logic [CNT_WIDTH-1:0] rem_q, rem_d, dsr_q, dsr_d;
  logic [BW-1:0]        bits_q, bits_d;
  logic                 busy_q, busy_d;
  logic [CNT_WIDTH:0]   rem_sh;
  logic                 ge;

  // The quotient register doubles as the dividend shift register: its MSB
  // feeds the partial remainder while the new quotient bit enters at the LSB.
  always_comb begin
    rem_sh = {rem_q, quo_q[ACC_WIDTH-1]};
    ge     = rem_sh >= {1'b0, dsr_q};
    quo_d  = quo_q;
    rem_d  = rem_q;
    dsr_d  = dsr_q;
    bits_d = bits_q;
    busy_d = busy_q;
    if (start && !busy_q) begin
      quo_d  = dividend;
      rem_d  = '0;
      dsr_d  = divisor;
      bits_d = BW'(ACC_WIDTH);
      busy_d = 1'b1;
    end else if (busy_q) begin
      quo_d  = {quo_q[ACC_WIDTH-2:0], ge};
      rem_d  = ge ? CNT_WIDTH'(rem_sh - {1'b0, dsr_q}) : rem_sh[CNT_WIDTH-1:0];
      bits_d = bits_q - BW'(1);
      if (bits_q == BW'(1)) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      quo_q  <= '0;
      rem_q  <= '0;
      dsr_q  <= '0;
      bits_q <= '0;
      busy_q <= 1'b0;
    end else begin
      quo_q  <= quo_d;
      rem_q  <= rem_d;
      dsr_q  <= dsr_d;
      bits_q <= bits_d;
      busy_q <= busy_d;
    end
  end

  assign quotient = quo_q;
  assign busy     = busy_q;
  assign done     = busy_q && (bits_q == BW'(1));

endmodule

// File: rtl/audio_decimator.sv
// rtl/audio_decimator.sv - box-car decimator producing clk_audio and a mono stereo sample word
//
// Purpose: averages strobed signed samples over each clk_audio period, divides
// by the sample count, rescales and presents {v,v} before the next rising edge.
// Ports:
//   clk, reset_n        pixel clock, synchronous active-low reset
//   sample_in           signed IN_WIDTH-bit sample, taken when sample_valid
//   sample_valid        sample accept strobe
//   mute                forces a zero word, sampled only at the update
//   clk_audio           registered audio clock, 2*(AUDIO_DIV+1) clk period
//   audio_sample_word   {left,right}, identical mono values
//   sample_strobe       one-cycle pulse on each word update
module audio_decimator
  import audio_decimator_pkg::*;
#(
  parameter int AUDIO_DIV = default_audio_div(1'b0),
  parameter int IN_WIDTH  = DEF_IN_WIDTH,
  parameter int OUT_WIDTH = DEF_OUT_WIDTH,
  parameter int CNT_WIDTH = DEF_CNT_WIDTH,
  parameter int ACC_WIDTH = DEF_ACC_WIDTH
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic signed [IN_WIDTH-1:0]  sample_in,
  input  logic                        sample_valid,
  input  logic                        mute,
  output logic                        clk_audio,
  output logic [2*OUT_WIDTH-1:0]      audio_sample_word,
  output logic                        sample_strobe
);

  localparam int DCW = $clog2(AUDIO_DIV + 1);
  localparam logic [ACC_WIDTH-1:0] POS_LIM = ACC_WIDTH'((1 << (IN_WIDTH - 1)) - 1);
  localparam logic [ACC_WIDTH-1:0] NEG_LIM = ACC_WIDTH'(1 << (IN_WIDTH - 1));

  logic [DCW-1:0]              div_cnt_q, div_cnt_d;
  logic                        clk_audio_q, clk_audio_d;
  logic signed [ACC_WIDTH-1:0] acc_q, acc_d, sample_ext;
  logic [CNT_WIDTH-1:0]        cnt_q, cnt_d;
  logic                        div_wrap, win_close, div_start, div_done, div_busy;
  logic [ACC_WIDTH-1:0]        acc_mag, quotient;
  logic [IN_WIDTH-1:0]         q_low, sat_full;
  logic [OUT_WIDTH-1:0]        sat_q;
  logic [2*OUT_WIDTH-1:0]      word_q;
  logic                        neg_q, rpt_q, strobe_q;
  dec_state_e                  state_q;

  assign div_wrap   = div_cnt_q == DCW'(AUDIO_DIV);
  // Window closes on the falling toggle, so the update lands in the low phase.
  assign win_close  = div_wrap && clk_audio_q;
  assign sample_ext = {{(ACC_WIDTH-IN_WIDTH){sample_in[IN_WIDTH-1]}}, sample_in};
  assign acc_mag    = acc_q[ACC_WIDTH-1] ? $unsigned(-acc_q) : $unsigned(acc_q);
  assign div_start  = win_close && (state_q == ST_IDLE) && (cnt_q != '0) && !div_busy;

  always_comb begin
    div_cnt_d   = div_wrap ? '0 : div_cnt_q + DCW'(1);
    clk_audio_d = div_wrap ? ~clk_audio_q : clk_audio_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    if (win_close) begin
      // A sample arriving in the close cycle opens the new window.
      acc_d = sample_valid ? sample_ext : '0;
      cnt_d = sample_valid ? CNT_WIDTH'(1) : '0;
    end else if (sample_valid && (cnt_q != '1)) begin
      acc_d = acc_q + sample_ext;
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      div_cnt_q   <= '0;
      clk_audio_q <= 1'b0;
      acc_q       <= '0;
      cnt_q       <= '0;
    end else begin
      div_cnt_q   <= div_cnt_d;
      clk_audio_q <= clk_audio_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
    end
  end

  serial_divider #(
    .ACC_WIDTH(ACC_WIDTH),
    .CNT_WIDTH(CNT_WIDTH)
  ) u_div (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (div_start),
    .dividend(acc_mag),
    .divisor (cnt_q),
    .quotient(quotient),
    .busy    (div_busy),
    .done    (div_done)
  );

  // Reapply sign (magnitude division truncates toward zero), clamp, then
  // keep the top OUT_WIDTH bits, which is an arithmetic right shift.
  always_comb begin
    q_low = quotient[IN_WIDTH-1:0];
    if (!neg_q) begin
      sat_full = (quotient > POS_LIM) ? {1'b0, {(IN_WIDTH-1){1'b1}}} : q_low;
    end else begin
      sat_full = (quotient > NEG_LIM) ? {1'b1, {(IN_WIDTH-1){1'b0}}} : IN_WIDTH'(0) - q_low;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      neg_q    <= 1'b0;
      rpt_q    <= 1'b0;
      sat_q    <= '0;
      word_q   <= '0;
      strobe_q <= 1'b0;
    end else begin
      strobe_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (win_close) begin
            neg_q <= acc_q[ACC_WIDTH-1];
            if (cnt_q == '0) begin
              rpt_q   <= 1'b1;
              state_q <= ST_OUT;
            end else begin
              rpt_q   <= 1'b0;
              state_q <= ST_DIV;
            end
          end
        end
        ST_DIV: begin
          if (div_done) state_q <= ST_SAT;
        end
        ST_SAT: begin
          sat_q   <= sat_full[IN_WIDTH-1 -: OUT_WIDTH];
          state_q <= ST_OUT;
        end
        ST_OUT: begin
          strobe_q <= 1'b1;
          if (mute)       word_q <= '0;
          else if (!rpt_q) word_q <= {sat_q, sat_q};
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign clk_audio         = clk_audio_q;
  assign audio_sample_word = word_q;
  assign sample_strobe     = strobe_q;

endmodule
